// File: rtl/stopwatch_pkg.sv
// Shared digit-select codes and BCD constants for the stopwatch datapath.
// No logic, no latency, no flow control.
package stopwatch_pkg;
    localparam int DIGIT_W = 4;

    typedef logic [DIGIT_W-1:0] bcd_t;

    localparam bcd_t BCD_MAX = 4'd9;

    // Must track the digit-setting FSM state encoding.
    localparam logic [2:0] SEL_NONE   = 3'd0;
    localparam logic [2:0] SEL_HUND   = 3'd1;
    localparam logic [2:0] SEL_TENTHS = 3'd2;
    localparam logic [2:0] SEL_SEC    = 3'd3;
    localparam logic [2:0] SEL_TENS   = 3'd4;
endpackage

// File: rtl/stopwatch_bcd_digit.sv
// One BCD digit: +1 mod 10 on carry-in or manual increment, carry-out on 9 with carry-in.
// Update one edge after cnt_en_i/inc_i; no backpressure.
module stopwatch_bcd_digit
    import stopwatch_pkg::*;
(
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic               cnt_en_i,
    input  logic               inc_i,
    output logic [DIGIT_W-1:0] digit_o,
    output logic               carry_o
);
    bcd_t digit_q, digit_d;

    // Values >= 10 cannot occur normally; treat them like 9 so they recover to 0.
    always_comb begin
        digit_d = digit_q;
        if (cnt_en_i || inc_i) begin
            digit_d = (digit_q >= BCD_MAX) ? '0 : digit_q + 4'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit_o = digit_q;
    assign carry_o = cnt_en_i && (digit_q == BCD_MAX);
endmodule

// File: rtl/stopwatch_counter_ctrl.sv
// Stopwatch core: 0.01 s prescaler, run/pause toggle, 4-digit BCD carry chain, manual digit set.
// Digits update one edge after tick/inc_i; pulse inputs, no backpressure.
module stopwatch_counter_ctrl
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV = 1_000_000
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic               start_stop_i,
    input  logic [2:0]         sel_i,
    input  logic               inc_i,
    output logic               dev_run_o,
    output logic [DIGIT_W-1:0] hundredths_o,
    output logic [DIGIT_W-1:0] tenths_o,
    output logic [DIGIT_W-1:0] seconds_o,
    output logic [DIGIT_W-1:0] tens_o
);
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    localparam logic [0:0] ST_PAUSED  = 1'b0;
    localparam logic [0:0] ST_RUNNING = 1'b1;

    logic [0:0]    run_q, run_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          tick;
    logic          sel_none;
    logic          man_inc;
    logic          carry_h, carry_t, carry_s, tens_carry_unused;

    assign sel_none = (sel_i == SEL_NONE) || (sel_i > SEL_TENS);
    assign tick     = (run_q == ST_RUNNING) && (presc_q == PRESC_MAX);
    assign man_inc  = inc_i && (run_q == ST_PAUSED);

    always_comb begin
        presc_d = presc_q;
        if (run_q == ST_RUNNING) begin
            presc_d = tick ? '0 : presc_q + 1'b1;
        end
    end

    // A start is refused while a digit is being set; a stop always wins.
    always_comb begin
        run_d = run_q;
        if (start_stop_i) begin
            if (run_q == ST_RUNNING) begin
                run_d = ST_PAUSED;
            end else if (sel_none) begin
                run_d = ST_RUNNING;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            run_q   <= ST_PAUSED;
            presc_q <= '0;
        end else begin
            run_q   <= run_d;
            presc_q <= presc_d;
        end
    end

    stopwatch_bcd_digit u_hund (
        .clk_i    (clk_i),
        .rstn_i   (rstn_i),
        .cnt_en_i (tick),
        .inc_i    (man_inc && (sel_i == SEL_HUND)),
        .digit_o  (hundredths_o),
        .carry_o  (carry_h)
    );

    stopwatch_bcd_digit u_tenths (
        .clk_i    (clk_i),
        .rstn_i   (rstn_i),
        .cnt_en_i (carry_h),
        .inc_i    (man_inc && (sel_i == SEL_TENTHS)),
        .digit_o  (tenths_o),
        .carry_o  (carry_t)
    );

    stopwatch_bcd_digit u_sec (
        .clk_i    (clk_i),
        .rstn_i   (rstn_i),
        .cnt_en_i (carry_t),
        .inc_i    (man_inc && (sel_i == SEL_SEC)),
        .digit_o  (seconds_o),
        .carry_o  (carry_s)
    );

    stopwatch_bcd_digit u_tens (
        .clk_i    (clk_i),
        .rstn_i   (rstn_i),
        .cnt_en_i (carry_s),
        .inc_i    (man_inc && (sel_i == SEL_TENS)),
        .digit_o  (tens_o),
        .carry_o  (tens_carry_unused)
    );

    assign dev_run_o = run_q;
endmodule

// File: tb/tb_stopwatch_counter_ctrl.sv
// Bench for stopwatch_counter_ctrl with TICK_DIV = 4, checked against an integer time model.
module tb_stopwatch_counter_ctrl;
    localparam int TD = 4;

    logic       clk_i = 1'b0;
    logic       rstn_i = 1'b0;
    logic       start_stop_i = 1'b0;
    logic [2:0] sel_i = 3'd0;
    logic       inc_i = 1'b0;
    logic       dev_run_o;
    logic [3:0] hundredths_o, tenths_o, seconds_o, tens_o;

    int n_cmp = 0;
    int n_err = 0;

    // Model: elapsed time as an integer count of hundredths, plus clocks into the current tick.
    int m_t     = 0;
    int m_phase = 0;
    bit m_run   = 1'b0;

    stopwatch_counter_ctrl #(.TICK_DIV(TD)) dut (
        .clk_i        (clk_i),
        .rstn_i       (rstn_i),
        .start_stop_i (start_stop_i),
        .sel_i        (sel_i),
        .inc_i        (inc_i),
        .dev_run_o    (dev_run_o),
        .hundredths_o (hundredths_o),
        .tenths_o     (tenths_o),
        .seconds_o    (seconds_o),
        .tens_o       (tens_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic int dval();
        return int'(tens_o) * 1000 + int'(seconds_o) * 100 + int'(tenths_o) * 10 + int'(hundredths_o);
    endfunction

    task automatic model_step();
        bit tk;
        int p, d;
        if (!rstn_i) begin
            m_run = 1'b0; m_t = 0; m_phase = 0;
        end else begin
            tk = m_run && (m_phase == TD - 1);
            if (tk) m_t = (m_t + 1) % 10000;
            if (inc_i && !m_run && sel_i >= 1 && sel_i <= 4) begin
                p = (sel_i == 1) ? 1 : (sel_i == 2) ? 10 : (sel_i == 3) ? 100 : 1000;
                d = (m_t / p) % 10;
                m_t = m_t - d * p + ((d + 1) % 10) * p;
            end
            if (m_run) m_phase = (m_phase + 1) % TD;
            if (start_stop_i) begin
                if (m_run) m_run = 1'b0;
                else if (sel_i == 0 || sel_i > 4) m_run = 1'b1;
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        model_step();
        #1;
    endtask

    task automatic drive(input bit st, input bit in, input logic [2:0] s);
        start_stop_i = st; inc_i = in; sel_i = s;
        cyc();
        start_stop_i = 1'b0; inc_i = 1'b0;
    endtask

    task automatic do_reset();
        rstn_i = 1'b0;
        drive(0, 0, 0);
        rstn_i = 1'b1;
    endtask

    task automatic test_reset();
        rstn_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start_stop_i = 1'($urandom); inc_i = 1'($urandom); sel_i = 3'($urandom);
            cyc();
        end
        n_cmp++;
        if (dval() !== 0 || dev_run_o !== 1'b0) begin
            n_err++;
            $display("FAIL reset_hold: time=%0d run=%b required time=0 run=0", dval(), dev_run_o);
        end
        rstn_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 3'($urandom));
            n_cmp++;
            if (dval() !== 0 || dev_run_o !== 1'b0) begin
                n_err++;
                $display("FAIL reset_release: time=%0d run=%b required time=0 run=0", dval(), dev_run_o);
            end
        end
    endtask

    task automatic test_count_wrap();
        int prev, v, wraps;
        wraps = 0;
        drive(1, 0, 0);
        prev = dval();
        for (int i = 1; i <= 40000; i++) begin
            drive(0, 0, 0);
            v = dval();
            if (prev == 9999 && v == 0) wraps++;
            if (i == 400) begin
                n_cmp++;
                if (v !== 100) begin
                    n_err++;
                    $display("FAIL count_400: time=%0d required 100", v);
                end
            end
            if (i % 500 == 0) begin
                n_cmp++;
                if (v !== m_t || dev_run_o !== m_run) begin
                    n_err++;
                    $display("FAIL count_track@%0d: time=%0d run=%b required time=%0d run=%b", i, v, dev_run_o, m_t, m_run);
                end
            end
            prev = v;
        end
        n_cmp++;
        if (wraps !== 1 || v !== 0) begin
            n_err++;
            $display("FAIL count_wrap: wraps=%0d final=%0d required wraps=1 final=0", wraps, v);
        end
        drive(1, 0, 0);
        n_cmp++;
        if (dev_run_o !== 1'b0) begin
            n_err++;
            $display("FAIL count_stop: run=%b required 0", dev_run_o);
        end
    endtask

    task automatic test_pause_resume();
        do_reset();
        drive(1, 0, 0);
        for (int i = 0; i < 5; i++) drive(0, 0, 0);
        drive(1, 0, 0);
        n_cmp++;
        if (hundredths_o !== 4'd1 || dev_run_o !== 1'b0) begin
            n_err++;
            $display("FAIL pause_stop: hund=%0d run=%b required hund=1 run=0", hundredths_o, dev_run_o);
        end
        for (int i = 0; i < 50; i++) drive(0, 0, 0);
        n_cmp++;
        if (dval() !== 1 || dval() !== m_t) begin
            n_err++;
            $display("FAIL pause_frozen: time=%0d required 1", dval());
        end
        drive(1, 0, 0);
        n_cmp++;
        if (dev_run_o !== 1'b1 || hundredths_o !== 4'd1) begin
            n_err++;
            $display("FAIL resume_edge: run=%b hund=%0d required run=1 hund=1", dev_run_o, hundredths_o);
        end
        drive(0, 0, 0);
        n_cmp++;
        if (hundredths_o !== 4'd1) begin
            n_err++;
            $display("FAIL resume_plus1: hund=%0d required 1", hundredths_o);
        end
        drive(0, 0, 0);
        n_cmp++;
        if (hundredths_o !== 4'd2) begin
            n_err++;
            $display("FAIL resume_plus2: hund=%0d required 2", hundredths_o);
        end
        drive(1, 0, 0);
    endtask

    task automatic test_manual_set();
        do_reset();
        for (int i = 0; i < 12; i++) begin
            drive(0, 1, 3);
            drive(0, 0, 3);
        end
        n_cmp++;
        if (seconds_o !== 4'd2 || dval() !== 200) begin
            n_err++;
            $display("FAIL manual_sec: time=%0d required 200", dval());
        end
        for (int i = 0; i < 9; i++) drive(0, 1, 1);
        n_cmp++;
        if (dval() !== 209) begin
            n_err++;
            $display("FAIL manual_hund9: time=%0d required 209", dval());
        end
        drive(0, 1, 1);
        n_cmp++;
        if (hundredths_o !== 4'd0 || tenths_o !== 4'd0 || dval() !== 200) begin
            n_err++;
            $display("FAIL manual_nocarry: time=%0d required 200", dval());
        end
    endtask

    task automatic test_ignored();
        int v0;
        drive(1, 0, 0);
        for (int i = 0; i < 3; i++) drive(0, 1, 3);
        n_cmp++;
        if (seconds_o !== 4'd2 || dval() !== m_t) begin
            n_err++;
            $display("FAIL ign_inc_running: time=%0d required %0d", dval(), m_t);
        end
        drive(1, 0, 0);
        v0 = dval();
        drive(1, 0, 2);
        n_cmp++;
        if (dev_run_o !== 1'b0) begin
            n_err++;
            $display("FAIL ign_start_sel2: run=%b required 0", dev_run_o);
        end
        drive(0, 1, 6);
        n_cmp++;
        if (dval() !== v0) begin
            n_err++;
            $display("FAIL ign_sel6: time=%0d required %0d", dval(), v0);
        end
        drive(1, 1, 2);
        n_cmp++;
        if (dev_run_o !== 1'b0 || dval() !== m_t) begin
            n_err++;
            $display("FAIL inc_with_start: time=%0d run=%b required time=%0d run=0", dval(), dev_run_o, m_t);
        end
    endtask

    task automatic test_coincident();
        do_reset();
        for (int i = 0; i < 9; i++) begin
            drive(0, 1, 3);
            drive(0, 1, 2);
            drive(0, 1, 1);
        end
        n_cmp++;
        if (dval() !== 999) begin
            n_err++;
            $display("FAIL coinc_preset: time=%0d required 999", dval());
        end
        drive(1, 0, 0);
        for (int i = 0; i < 3; i++) drive(0, 0, 0);
        drive(1, 0, 0);
        n_cmp++;
        if (dval() !== 1000 || dev_run_o !== 1'b0) begin
            n_err++;
            $display("FAIL coinc_stop_tick: time=%0d run=%b required time=1000 run=0", dval(), dev_run_o);
        end
        for (int i = 0; i < 10; i++) drive(0, 0, 0);
        n_cmp++;
        if (dval() !== 1000) begin
            n_err++;
            $display("FAIL coinc_frozen: time=%0d required 1000", dval());
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rstn_i       = ($urandom_range(0, 199) != 0);
            start_stop_i = ($urandom_range(0, 15) == 0);
            inc_i        = ($urandom_range(0, 3) == 0);
            sel_i        = $urandom_range(0, 1) ? 3'd0 : 3'($urandom_range(0, 7));
            cyc();
            n_cmp++;
            if (dval() !== m_t || dev_run_o !== m_run) begin
                n_err++;
                $display("FAIL random@%0d: time=%0d run=%b required time=%0d run=%b", i, dval(), dev_run_o, m_t, m_run);
            end
        end
        rstn_i = 1'b1; start_stop_i = 1'b0; inc_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_count_wrap();
        test_pause_resume();
        test_manual_set();
        test_ignored();
        test_coincident();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/stopwatch_counter_ctrl.md
# stopwatch_counter_ctrl

Time-keeping controller for the lab stopwatch. It divides the system clock into 0.01 s ticks and runs/pauses on a start/stop pulse. It advances a four-digit BCD time value (tens of seconds, seconds, tenths, hundredths) with a carry chain, and applies per-digit manual increments requested by the digit-setting FSM. It sits between the button front end and the seven-segment driver and feeds `dev_run_o` back to the setting FSM.

## Interface
- `TICK_DIV`, default 1_000_000: clk cycles per 0.01 s tick; must be ≥ 2.
- `clk_i`  in  1  system clock
- `rstn_i`  in  1  reset, synchronous, active-low
- `start_stop_i`  in  1  one-cycle pulse, toggles run/pause
- `sel_i`  in  3  digit selected by setting FSM: 0 none, 1 hundredths, 2 tenths, 3 seconds, 4 tens; 5–7 treated as 0
- `inc_i`  in  1  one-cycle pulse, increment selected digit
- `dev_run_o`  out  1  1 = counting
- `hundredths_o`  out  4  BCD 0–9
- `tenths_o`  out  4  BCD 0–9
- `seconds_o`  out  4  BCD 0–9
- `tens_o`  out  4  BCD 0–9

## Operation
- **Run/pause state.** Register `dev_run_o` has two states: PAUSED (0) and RUNNING (1).
  - PAUSED→RUNNING on `start_stop_i` = 1 when `sel_i` ∈ {0, 5–7}.
  - RUNNING→PAUSED on `start_stop_i` = 1 regardless of `sel_i`.
  - `start_stop_i` in PAUSED with `sel_i` ∈ 1–4 is ignored: no start while a digit is being set.
- **Prescaler.**
  - Width is $clog2(TICK_DIV).
  - It increments only while `dev_run_o` = 1.
  - At TICK_DIV−1 it asserts internal `tick` for that cycle and wraps to 0.
  - On pause it holds its value; resuming continues the partial period.
- **Counting on `tick`.**
  - Hundredths +1.
  - Each digit wraps 9→0 and carries into the next digit in the same cycle: hundredths→tenths→seconds→tens.
  - 99.99 + tick → 00.00, with no overflow flag.
- **Manual increment.**
  - Applies when `inc_i` = 1, `dev_run_o` = 0 and `sel_i` ∈ 1–4.
  - The selected digit goes +1 mod 10. There is no carry; other digits are unchanged.
  - `inc_i` is ignored otherwise.
- **Illegal digit values** (≥ 10, unreachable in normal operation) are corrected to 0 on the next update of that digit.

## Timing
- **Reset values** (`rstn_i` = 0 at a clk edge): `dev_run_o` = 0, all digits = 0, prescaler = 0. Reset wins over every other input in the same cycle. A mid-run reset zeroes everything on that edge.
- **Start latency.** `start_stop_i` sampled at edge n → `dev_run_o` = 1 after edge n. The prescaler first increments at edge n+1. The first tick is visible on the digits after edge n+TICK_DIV.
- **Stop latency.** A stop pulse at edge n freezes the prescaler and digits from edge n on.
  - If a tick coincides with that edge, the tick is still applied: the update uses pre-edge `dev_run_o`.
- **Digit updates** are registered: one edge after `tick` or `inc_i`.
- **Inputs** `start_stop_i` and `inc_i` are assumed single-cycle pulses. A held level re-triggers every cycle; edge detection is upstream.
- **Simultaneous `inc_i` and `start_stop_i` while paused:** the increment is applied (pre-edge `dev_run_o` = 0) and the start is ignored if `sel_i` ≠ 0.

## Structure
- **Shared package `stopwatch_pkg`:**
  - digit-select codes SEL_NONE = 0, SEL_HUND = 1, SEL_TENTHS = 2, SEL_SEC = 3, SEL_TENS = 4, matching the setting FSM state encoding;
  - BCD_MAX = 9;
  - digit width 4.
- **Sub-module `stopwatch_bcd_digit`**, instantiated four times:
  - inputs `clk_i`, `rstn_i`, `cnt_en_i` (carry/tick in), `inc_i` (no-carry increment);
  - outputs `digit_o`, `carry_o` = `cnt_en_i` && `digit_o` == 9.
- **Top level:** prescaler, run/pause register, select decode and carry chain.

## Test plan
All scenarios use TICK_DIV = 4.
1. **Reset.** Hold `rstn_i` = 0 for 3 cycles with random inputs → all digits 0, `dev_run_o` = 0. Release → outputs stay 0 until start.
2. **Count and wrap.** Start pulse, run 4 × 10 000 cycles → wrap 99.99→00.00 observed once. The tick at 400 cycles after start gives 01.00.
3. **Pause/resume.**
   - Start, run 6 cycles (hundredths = 1, prescaler = 2), then stop.
   - Idle 50 cycles → digits frozen.
   - Restart → hundredths = 2 exactly 2 cycles after `dev_run_o` rises.
4. **Manual set.**
   - Paused, `sel_i` = 3, 12 `inc_i` pulses → seconds = 2, other digits unchanged.
   - `sel_i` = 1 at hundredths 9, `inc_i` → 0 with no carry into tenths.
5. **Ignored inputs.**
   - `inc_i` while running → no change.
   - `start_stop_i` with `sel_i` = 2 while paused → `dev_run_o` stays 0.
   - `sel_i` = 6 with `inc_i` → no change.
6. **Coincident stop + tick.** Stop pulse on the tick cycle at 09.99 → display 10.00 and `dev_run_o` = 0 after the same edge.
